// File: rtl/centroid_accumulator.sv
// Per-frame centroid accumulator: sums x, y and count of masked pixels and
// hands a one-entry result register to a downstream divider.
module centroid_accumulator #(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480,
    parameter int DATA_W = 24
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic              in_sof,
    input  logic              in_mask,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_sum_x,
    output logic [DATA_W-1:0] out_sum_y,
    output logic [DATA_W-1:0] out_count,
    output logic              out_overflow,
    output logic              out_dropped
);

    localparam int XW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
    localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam logic [XW-1:0]     X_LAST = XW'(WIDTH - 1);
    localparam logic [YW-1:0]     Y_LAST = YW'(HEIGHT - 1);
    localparam logic [DATA_W-1:0] SAT    = '1;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t r_state, w_state_nxt;

    logic [XW-1:0]     r_x, w_px, w_x_nxt;
    logic [YW-1:0]     r_y, w_py, w_y_nxt;
    logic [DATA_W-1:0] r_acc_x, r_acc_y, r_acc_cnt;
    logic              r_ovf;
    logic [DATA_W-1:0] w_base_x, w_base_y, w_base_cnt;
    logic [DATA_W:0]   w_add_x, w_add_y, w_add_cnt;
    logic [DATA_W-1:0] w_new_x, w_new_y, w_new_cnt;
    logic              w_new_ovf, w_sof, w_eof, w_load, w_drop;

    logic [DATA_W-1:0] r_sum_x, r_sum_y, r_count;
    logic              r_out_ovf, r_dropped;

    // A start-of-frame pixel is evaluated as (0,0) against empty accumulators,
    // so the frame restart and the first accumulation share one cycle.
    always_comb begin
        w_sof      = in_valid & in_sof;
        w_px       = w_sof ? '0 : r_x;
        w_py       = w_sof ? '0 : r_y;
        w_base_x   = w_sof ? '0 : r_acc_x;
        w_base_y   = w_sof ? '0 : r_acc_y;
        w_base_cnt = w_sof ? '0 : r_acc_cnt;

        w_add_x    = {1'b0, w_base_x}   + (DATA_W + 1)'(w_px);
        w_add_y    = {1'b0, w_base_y}   + (DATA_W + 1)'(w_py);
        w_add_cnt  = {1'b0, w_base_cnt} + (DATA_W + 1)'(1);

        w_new_x    = w_base_x;
        w_new_y    = w_base_y;
        w_new_cnt  = w_base_cnt;
        w_new_ovf  = w_sof ? 1'b0 : r_ovf;
        if (in_mask) begin
            w_new_x   = w_add_x[DATA_W]   ? SAT : w_add_x[DATA_W-1:0];
            w_new_y   = w_add_y[DATA_W]   ? SAT : w_add_y[DATA_W-1:0];
            w_new_cnt = w_add_cnt[DATA_W] ? SAT : w_add_cnt[DATA_W-1:0];
            w_new_ovf = w_new_ovf | w_add_x[DATA_W] | w_add_y[DATA_W]
                      | w_add_cnt[DATA_W];
        end

        w_eof = in_valid && (w_px == X_LAST) && (w_py == Y_LAST);

        w_x_nxt = w_px + 1'b1;
        w_y_nxt = w_py;
        if (w_px == X_LAST) begin
            w_x_nxt = '0;
            w_y_nxt = (w_py == Y_LAST) ? '0 : w_py + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_x       <= '0;
            r_y       <= '0;
            r_acc_x   <= '0;
            r_acc_y   <= '0;
            r_acc_cnt <= '0;
            r_ovf     <= 1'b0;
        end else if (in_valid) begin
            r_x <= w_x_nxt;
            r_y <= w_y_nxt;
            if (w_eof) begin
                r_acc_x   <= '0;
                r_acc_y   <= '0;
                r_acc_cnt <= '0;
                r_ovf     <= 1'b0;
            end else begin
                r_acc_x   <= w_new_x;
                r_acc_y   <= w_new_y;
                r_acc_cnt <= w_new_cnt;
                r_ovf     <= w_new_ovf;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_drop      = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_eof) begin
                    w_state_nxt = ST_FULL;
                    w_load      = 1'b1;
                end
            end
            ST_FULL: begin
                if (w_eof && out_ready) begin
                    w_load = 1'b1;
                end else if (w_eof) begin
                    w_drop = 1'b1;
                end else if (out_ready) begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            default: w_state_nxt = ST_EMPTY;
        endcase
    end

    // An empty frame reports count=1 so the divider never divides by zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sum_x   <= '0;
            r_sum_y   <= '0;
            r_count   <= '0;
            r_out_ovf <= 1'b0;
            r_dropped <= 1'b0;
        end else begin
            r_dropped <= w_drop;
            if (w_load) begin
                r_out_ovf <= w_new_ovf;
                if (w_new_cnt == '0) begin
                    r_sum_x <= '0;
                    r_sum_y <= '0;
                    r_count <= DATA_W'(1);
                end else begin
                    r_sum_x <= w_new_x;
                    r_sum_y <= w_new_y;
                    r_count <= w_new_cnt;
                end
            end
        end
    end

    assign out_valid    = (r_state == ST_FULL);
    assign out_sum_x    = r_sum_x;
    assign out_sum_y    = r_sum_y;
    assign out_count    = r_count;
    assign out_overflow = r_out_ovf;
    assign out_dropped  = r_dropped;

endmodule

// File: tb/tb_centroid_accumulator.sv
// Scoreboard bench for centroid_accumulator: a 4x2 instance for framing and
// handshake scenarios, and an 8x2 instance with 4-bit outputs for saturation.
module tb_centroid_accumulator;

    typedef struct {
        logic [23:0] sx;
        logic [23:0] sy;
        logic [23:0] cnt;
        logic        ovf;
    } res_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, in_valid, in_sof, in_mask, out_ready;
    logic        out_valid, out_overflow, out_dropped;
    logic [23:0] out_sum_x, out_sum_y, out_count;

    logic        s_in_valid, s_in_sof, s_in_mask, s_out_ready;
    logic        s_out_valid, s_out_overflow, s_out_dropped;
    logic [3:0]  s_out_sum_x, s_out_sum_y, s_out_count;

    int   checks = 0;
    int   errors = 0;
    int   drops  = 0;
    res_t sb[$];

    centroid_accumulator #(.WIDTH(4), .HEIGHT(2), .DATA_W(24)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_sof(in_sof),
        .in_mask(in_mask), .out_valid(out_valid), .out_ready(out_ready),
        .out_sum_x(out_sum_x), .out_sum_y(out_sum_y), .out_count(out_count),
        .out_overflow(out_overflow), .out_dropped(out_dropped)
    );

    centroid_accumulator #(.WIDTH(8), .HEIGHT(2), .DATA_W(4)) dut_s (
        .clk(clk), .reset(reset), .in_valid(s_in_valid), .in_sof(s_in_sof),
        .in_mask(s_in_mask), .out_valid(s_out_valid), .out_ready(s_out_ready),
        .out_sum_x(s_out_sum_x), .out_sum_y(s_out_sum_y), .out_count(s_out_count),
        .out_overflow(s_out_overflow), .out_dropped(s_out_dropped)
    );

    // Reference result of one frame: saturating running sums, empty frame -> count 1.
    function automatic res_t model(input int w, input int h, input int dw,
                                   input logic [15:0] m);
        res_t   r;
        longint mx, sx, sy, c;
        logic   ovf;
        mx = (longint'(1) << dw) - 1;
        sx = 0; sy = 0; c = 0; ovf = 1'b0;
        for (int i = 0; i < w * h; i++) begin
            if (m[i]) begin
                sx += i % w;
                sy += i / w;
                c  += 1;
                if (sx > mx) begin sx = mx; ovf = 1'b1; end
                if (sy > mx) begin sy = mx; ovf = 1'b1; end
                if (c  > mx) begin c  = mx; ovf = 1'b1; end
            end
        end
        if (c == 0) begin sx = 0; sy = 0; c = 1; end
        r.sx = 24'(sx); r.sy = 24'(sy); r.cnt = 24'(c); r.ovf = ovf;
        return r;
    endfunction

    task automatic pix(input logic sof, input logic m, input logic rdy);
        @(negedge clk);
        if (out_dropped === 1'b1) drops++;
        in_valid = 1'b1; in_sof = sof; in_mask = m; out_ready = rdy;
    endtask

    task automatic idle(input logic rdy);
        @(negedge clk);
        if (out_dropped === 1'b1) drops++;
        in_valid = 1'b0; in_sof = 1'b0; in_mask = 1'b0; out_ready = rdy;
    endtask

    task automatic send_frame(input logic [7:0] m, input logic rdy,
                              input logic last_rdy, input bit keep);
        for (int i = 0; i < 8; i++) pix(i == 0, m[i], (i == 7) ? last_rdy : rdy);
        if (keep) sb.push_back(model(4, 2, 24, {8'h00, m}));
    endtask

    task automatic test_reset;
        reset = 1'b1;
        @(negedge clk);
        in_valid = 1'b1; in_sof = 1'b1; in_mask = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        reset = 1'b0; in_valid = 1'b0; in_sof = 1'b0; in_mask = 1'b0; out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", out_valid); end
        checks++; if (out_sum_x !== 24'd0) begin errors++; $display("FAIL reset_sum_x got %0d want 0", out_sum_x); end
        checks++; if (out_sum_y !== 24'd0) begin errors++; $display("FAIL reset_sum_y got %0d want 0", out_sum_y); end
        checks++; if (out_count !== 24'd0) begin errors++; $display("FAIL reset_count got %0d want 0", out_count); end
        checks++; if (out_overflow !== 1'b0 || out_dropped !== 1'b0) begin errors++; $display("FAIL reset_flags got ovf=%b drop=%b want 0 0", out_overflow, out_dropped); end
        checks++; if (s_out_valid !== 1'b0 || s_out_count !== 4'd0) begin errors++; $display("FAIL reset_sat_dut got valid=%b count=%0d want 0 0", s_out_valid, s_out_count); end
    endtask

    task automatic test_basic;
        res_t e;
        send_frame(8'b1000_0100, 1'b0, 1'b0, 1'b1);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid got %b want 0", out_valid); end
        idle(1'b0);
        checks++; if (sb.size() == 0) begin errors++; $display("FAIL basic_sb got empty want 1 entry"); end
        else begin
            e = sb.pop_front();
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %b want 1", out_valid); end
            checks++; if (out_sum_x !== e.sx) begin errors++; $display("FAIL basic_sum_x got %0d want %0d", out_sum_x, e.sx); end
            checks++; if (out_sum_y !== e.sy) begin errors++; $display("FAIL basic_sum_y got %0d want %0d", out_sum_y, e.sy); end
            checks++; if (out_count !== e.cnt) begin errors++; $display("FAIL basic_count got %0d want %0d", out_count, e.cnt); end
            checks++; if (out_overflow !== e.ovf) begin errors++; $display("FAIL basic_ovf got %b want %b", out_overflow, e.ovf); end
        end
        idle(1'b1);
        idle(1'b0);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_drain got %b want 0", out_valid); end
    endtask

    task automatic test_empty_frame;
        res_t e;
        send_frame(8'h00, 1'b0, 1'b0, 1'b1);
        idle(1'b0);
        e = sb.pop_front();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL empty_valid got %b want 1", out_valid); end
        checks++; if (out_sum_x !== e.sx || out_sum_y !== e.sy) begin errors++; $display("FAIL empty_sums got %0d,%0d want %0d,%0d", out_sum_x, out_sum_y, e.sx, e.sy); end
        checks++; if (out_count !== e.cnt) begin errors++; $display("FAIL empty_count got %0d want %0d", out_count, e.cnt); end
        idle(1'b1);
        idle(1'b0);
    endtask

    task automatic test_drop;
        res_t e;
        drops = 0;
        send_frame(8'h21, 1'b0, 1'b0, 1'b1);
        idle(1'b0);
        e = sb[0];
        for (int i = 0; i < 8; i++) begin
            pix(i == 0, 1'b1, 1'b0);
            checks++;
            if (out_valid !== 1'b1 || out_sum_x !== e.sx || out_sum_y !== e.sy || out_count !== e.cnt)
            begin errors++; $display("FAIL drop_hold cyc %0d got v=%b %0d,%0d,%0d want 1 %0d,%0d,%0d", i, out_valid, out_sum_x, out_sum_y, out_count, e.sx, e.sy, e.cnt); end
        end
        idle(1'b0);
        idle(1'b0);
        checks++; if (out_valid !== 1'b1 || out_sum_x !== e.sx || out_count !== e.cnt) begin errors++; $display("FAIL drop_after got v=%b x=%0d c=%0d want 1 %0d %0d", out_valid, out_sum_x, out_count, e.sx, e.cnt); end
        checks++; if (drops !== 1) begin errors++; $display("FAIL drop_pulses got %0d want 1", drops); end
        void'(sb.pop_front());
        idle(1'b1);
        idle(1'b0);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drop_drain got %b want 0", out_valid); end
    endtask

    task automatic test_back_to_back;
        res_t e;
        drops = 0;
        send_frame(8'h0F, 1'b0, 1'b0, 1'b1);
        idle(1'b0);
        e = sb.pop_front();
        checks++; if (out_valid !== 1'b1 || out_sum_x !== e.sx || out_count !== e.cnt) begin errors++; $display("FAIL b2b_first got v=%b x=%0d c=%0d want 1 %0d %0d", out_valid, out_sum_x, out_count, e.sx, e.cnt); end
        send_frame(8'hC0, 1'b0, 1'b1, 1'b1);
        idle(1'b0);
        e = sb.pop_front();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid got %b want 1", out_valid); end
        checks++; if (out_sum_x !== e.sx || out_sum_y !== e.sy || out_count !== e.cnt) begin errors++; $display("FAIL b2b_data got %0d,%0d,%0d want %0d,%0d,%0d", out_sum_x, out_sum_y, out_count, e.sx, e.sy, e.cnt); end
        idle(1'b1);
        idle(1'b0);
        checks++; if (drops !== 0 || out_valid !== 1'b0) begin errors++; $display("FAIL b2b_end got drops=%0d v=%b want 0 0", drops, out_valid); end
    endtask

    task automatic test_sof_mid;
        res_t e;
        drops = 0;
        for (int i = 0; i < 5; i++) pix(i == 0, 1'b1, 1'b0);
        send_frame(8'h02, 1'b0, 1'b0, 1'b1);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL sofmid_early got %b want 0", out_valid); end
        idle(1'b0);
        e = sb.pop_front();
        checks++; if (out_valid !== 1'b1 || out_sum_x !== e.sx || out_sum_y !== e.sy || out_count !== e.cnt) begin errors++; $display("FAIL sofmid_data got v=%b %0d,%0d,%0d want 1 %0d,%0d,%0d", out_valid, out_sum_x, out_sum_y, out_count, e.sx, e.sy, e.cnt); end
        checks++; if (drops !== 0) begin errors++; $display("FAIL sofmid_drop got %0d want 0", drops); end
        idle(1'b1);
        idle(1'b0);
    endtask

    task automatic test_reset_mid;
        res_t e;
        send_frame(8'h01, 1'b0, 1'b0, 1'b1);
        idle(1'b0);
        pix(1'b1, 1'b1, 1'b0);
        pix(1'b0, 1'b1, 1'b0);
        pix(1'b0, 1'b1, 1'b0);
        @(negedge clk);
        reset = 1'b1; in_valid = 1'b1; in_sof = 1'b0; in_mask = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        reset = 1'b0; in_valid = 1'b0; in_mask = 1'b0; out_ready = 1'b0;
        sb.delete();
        checks++; if (out_valid !== 1'b0 || out_sum_x !== 24'd0 || out_count !== 24'd0) begin errors++; $display("FAIL rstmid_clear got v=%b x=%0d c=%0d want 0 0 0", out_valid, out_sum_x, out_count); end
        send_frame(8'h80, 1'b0, 1'b0, 1'b1);
        idle(1'b0);
        e = sb.pop_front();
        checks++; if (out_valid !== 1'b1 || out_sum_x !== e.sx || out_sum_y !== e.sy || out_count !== e.cnt) begin errors++; $display("FAIL rstmid_fresh got v=%b %0d,%0d,%0d want 1 %0d,%0d,%0d", out_valid, out_sum_x, out_sum_y, out_count, e.sx, e.sy, e.cnt); end
        idle(1'b1);
        idle(1'b0);
    endtask

    task automatic test_saturation;
        res_t        e;
        logic [15:0] pat [2];
        pat[0] = 16'hFFFF;
        pat[1] = 16'h0002;
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < 16; i++) begin
                @(negedge clk);
                s_in_valid = 1'b1; s_in_sof = (i == 0); s_in_mask = pat[f][i]; s_out_ready = 1'b0;
            end
            sb.push_back(model(8, 2, 4, pat[f]));
            @(negedge clk);
            s_in_valid = 1'b0; s_in_sof = 1'b0; s_in_mask = 1'b0;
            e = sb.pop_front();
            checks++; if (s_out_valid !== 1'b1) begin errors++; $display("FAIL sat%0d_valid got %b want 1", f, s_out_valid); end
            checks++; if (s_out_sum_x !== e.sx[3:0] || s_out_sum_y !== e.sy[3:0]) begin errors++; $display("FAIL sat%0d_sums got %0d,%0d want %0d,%0d", f, s_out_sum_x, s_out_sum_y, e.sx, e.sy); end
            checks++; if (s_out_count !== e.cnt[3:0] || s_out_overflow !== e.ovf) begin errors++; $display("FAIL sat%0d_cnt_ovf got %0d,%b want %0d,%b", f, s_out_count, s_out_overflow, e.cnt, e.ovf); end
            s_out_ready = 1'b1;
            @(negedge clk);
            s_out_ready = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_mask = 1'b0; out_ready = 1'b0;
        s_in_valid = 1'b0; s_in_sof = 1'b0; s_in_mask = 1'b0; s_out_ready = 1'b0;
        test_reset;
        test_basic;
        test_empty_frame;
        test_drop;
        test_back_to_back;
        test_sof_mid;
        test_reset_mid;
        test_saturation;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
